// File: rtl/instmem_pkg.sv
// instmem_pkg -- shared definitions for the instruction memory slice.
// Holds the controller state type and the default geometry/latency
// constants used as parameter defaults by the interface, RAM and top.
package instmem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF  = 4096;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/instmem_if.sv
// instmem_if -- bus bundle between a host and instmem_pipe.
// Write side : we_IM, wr_auto, wr_addr, dataIM -> wr_err
// Read side  : rd_req, addIM -> rd_ready, rd_valid, outIM, rd_err
// Control    : clr_start -> busy
// master = host side (drives requests), slave = memory side.
interface instmem_if import instmem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              we_IM;
  logic              wr_auto;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] dataIM;
  logic              wr_err;

  logic              rd_req;
  logic              rd_ready;
  logic [ADDR_W-1:0] addIM;
  logic              rd_valid;
  logic [DATA_W-1:0] outIM;
  logic              rd_err;

  logic              clr_start;
  logic              busy;

  modport master (
    output we_IM, wr_auto, wr_addr, dataIM, rd_req, addIM, clr_start,
    input  wr_err, rd_ready, rd_valid, outIM, rd_err, busy
  );

  modport slave (
    input  we_IM, wr_auto, wr_addr, dataIM, rd_req, addIM, clr_start,
    output wr_err, rd_ready, rd_valid, outIM, rd_err, busy
  );

endinterface

// File: rtl/instmem_ram.sv
// instmem_ram -- plain storage array, one synchronous write port and one
// synchronous read port, no reset.
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
// A same-address read and write in one cycle returns the OLD word; the
// caller is responsible for any forwarding it needs. rdata holds while re=0.
module instmem_ram import instmem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update and registered read; callers keep addresses below DEPTH.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instmem_pipe.sv
// instmem_pipe -- instruction memory with pipelined reads, auto-increment
// write pointer, range checking and a one-word-per-cycle clear engine.
// Ports: clk, rst_n (async, active-low), bus (instmem_if.slave) carrying
// the write, read and clear handshakes. Reads return RD_LAT (1 or 2)
// cycles after acceptance; writes are write-first with respect to reads.
module instmem_pipe import instmem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  instmem_if.slave  bus
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wptr;
  logic              wr_err_q;

  logic              idle;
  logic              wr_req;
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_tgt;
  logic              rd_acc;
  logic              rd_oob;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              s1_valid;
  logic              s1_oob;
  logic              s1_byp;
  logic [DATA_W-1:0] s1_byp_data;
  logic [DATA_W-1:0] s1_data;

  assign idle   = (state == IDLE);
  // A write presented alongside an accepted clr_start is discarded silently.
  assign wr_req = idle & bus.we_IM & ~bus.clr_start;
  assign wr_tgt = bus.wr_auto ? wptr : bus.wr_addr;
  assign wr_ok  = wr_req & in_range(wr_tgt);
  assign rd_acc = bus.rd_req & bus.rd_ready;
  assign rd_oob = ~in_range(bus.addIM);

  assign bus.busy     = (state == CLEAR);
  assign bus.rd_ready = idle;
  assign bus.wr_err   = wr_err_q;

  // Next-state logic: clr_start only matters in IDLE, CLEAR ends after the
  // last word has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM write port is owned by the clear engine while clearing, otherwise
  // by host writes that passed the range check.
  always_comb begin
    ram_we    = wr_ok;
    ram_waddr = wr_tgt;
    ram_wdata = bus.dataIM;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end
  end

  // Controller registers: state, clear counter, write pointer, drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      wptr     <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (state == CLEAR) clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
      if (wr_ok)          wptr    <= (wr_tgt == LAST) ? '0 : wr_tgt + 1'b1;
      wr_err_q <= wr_req & ~in_range(wr_tgt);
    end
  end

  instmem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_acc & ~rd_oob),
    .raddr (bus.addIM),
    .rdata (ram_rdata)
  );

  // First read stage. The select flags only move on an accepted read so the
  // muxed data holds between reads; s1_oob resets high to force outIM=0.
  // s1_byp forwards same-cycle write data because the RAM is read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_oob      <= 1'b1;
      s1_byp      <= 1'b0;
      s1_byp_data <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_oob      <= rd_oob;
        s1_byp      <= wr_ok & (wr_tgt == bus.addIM);
        s1_byp_data <= bus.dataIM;
      end
    end
  end

  assign s1_data = s1_oob ? '0 : (s1_byp ? s1_byp_data : ram_rdata);

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2;
      logic              e2;
      logic [DATA_W-1:0] d2;

      // Extra output register; data only captured on valid so it holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          e2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= s1_valid;
          e2 <= s1_valid & s1_oob;
          if (s1_valid) d2 <= s1_data;
        end
      end

      assign bus.rd_valid = v2;
      assign bus.rd_err   = e2;
      assign bus.outIM    = d2;
    end else begin : g_lat1
      assign bus.rd_valid = s1_valid;
      assign bus.rd_err   = s1_valid & s1_oob;
      assign bus.outIM    = s1_data;
    end
  endgenerate

endmodule
